// File: rtl/multi_operand_sum_using_fifos.sv
// multi_operand_sum_using_fifos: N-operand adder joining per-channel input FIFOs into one output FIFO.
// Optional feature: define MULTI_OPERAND_SUM_SATURATE_EN to saturate the sum instead of wrapping.
module multi_operand_sum_using_fifos #(
    parameter int width     = 8,
    parameter int n_inputs  = 3,
    parameter int in_depth  = 4,
    parameter int out_depth = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_inputs-1:0]       in_valid,
    output logic [n_inputs-1:0]       in_ready,
    input  logic [n_inputs*width-1:0] in_data,
    output logic                      sum_valid,
    input  logic                      sum_ready,
    output logic [width-1:0]          sum_data
);

    localparam int IAW = $clog2(in_depth);
    localparam int OAW = $clog2(out_depth);
    localparam int SW  = width + $clog2(n_inputs);

    logic                en_q;

    logic [IAW:0]        in_wptr_q [n_inputs];
    logic [IAW:0]        in_wptr_d [n_inputs];
    logic [IAW:0]        in_rptr_q [n_inputs];
    logic [IAW:0]        in_rptr_d [n_inputs];
    logic [width-1:0]    in_mem_q  [n_inputs][in_depth];
    logic [n_inputs-1:0] in_full;
    logic [n_inputs-1:0] in_empty;
    logic [n_inputs-1:0] in_push;

    logic [OAW:0]        out_wptr_q;
    logic [OAW:0]        out_wptr_d;
    logic [OAW:0]        out_rptr_q;
    logic [OAW:0]        out_rptr_d;
    logic [width-1:0]    out_mem_q [out_depth];
    logic                out_full;
    logic                out_empty;
    logic                out_pop;
    logic                join_fire;

    logic [SW-1:0]       sum_wide;
    logic [width-1:0]    sum_red;

    // Input readiness is withheld until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    // Per-channel occupancy flags from the wrap-extended pointers
    always_comb begin
        for (int i = 0; i < n_inputs; i++) begin
            in_empty[i] = (in_wptr_q[i] == in_rptr_q[i]);
            in_full[i]  = (in_wptr_q[i][IAW-1:0] == in_rptr_q[i][IAW-1:0])
                       && (in_wptr_q[i][IAW] != in_rptr_q[i][IAW]);
        end
    end

    assign in_ready  = {n_inputs{en_q}} & ~in_full;
    assign in_push   = in_valid & in_ready;

    assign out_empty = (out_wptr_q == out_rptr_q);
    assign out_full  = (out_wptr_q[OAW-1:0] == out_rptr_q[OAW-1:0])
                    && (out_wptr_q[OAW] != out_rptr_q[OAW]);
    assign out_pop   = sum_valid & sum_ready;

    // Join only on registered state, so a same-cycle pop never frees room
    assign join_fire = ~(|in_empty) & ~out_full;

    // Next-state pointers: pushes advance write, joins/pops advance read
    always_comb begin
        for (int i = 0; i < n_inputs; i++) begin
            in_wptr_d[i] = in_wptr_q[i] + {{IAW{1'b0}}, in_push[i]};
            in_rptr_d[i] = in_rptr_q[i] + {{IAW{1'b0}}, join_fire};
        end
        out_wptr_d = out_wptr_q + {{OAW{1'b0}}, join_fire};
        out_rptr_d = out_rptr_q + {{OAW{1'b0}}, out_pop};
    end

    // Pointer registers; reset empties every FIFO at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < n_inputs; i++) begin
                in_wptr_q[i] <= '0;
                in_rptr_q[i] <= '0;
            end
            out_wptr_q <= '0;
            out_rptr_q <= '0;
        end else begin
            for (int i = 0; i < n_inputs; i++) begin
                in_wptr_q[i] <= in_wptr_d[i];
                in_rptr_q[i] <= in_rptr_d[i];
            end
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
        end
    end

    // Input FIFO storage, written on each channel handshake
    always_ff @(posedge clk) begin
        for (int i = 0; i < n_inputs; i++) begin
            if (in_push[i]) begin
                in_mem_q[i][in_wptr_q[i][IAW-1:0]] <= in_data[i*width +: width];
            end
        end
    end

    // Wide sum of all channel heads
    always_comb begin
        sum_wide = '0;
        for (int i = 0; i < n_inputs; i++) begin
            sum_wide = sum_wide + SW'(in_mem_q[i][in_rptr_q[i][IAW-1:0]]);
        end
    end

`ifdef MULTI_OPERAND_SUM_SATURATE_EN
    assign sum_red = (|sum_wide[SW-1:width]) ? {width{1'b1}}
                                              : sum_wide[width-1:0];
`else
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum_wide[SW-1:width];
    assign sum_red = sum_wide[width-1:0];
`endif

    // Output FIFO storage, written when a join fires
    always_ff @(posedge clk) begin
        if (join_fire) begin
            out_mem_q[out_wptr_q[OAW-1:0]] <= sum_red;
        end
    end

    assign sum_valid = ~out_empty;
    assign sum_data  = out_empty ? '0 : out_mem_q[out_rptr_q[OAW-1:0]];

endmodule

// File: doc/multi_operand_sum_using_fifos.md
# multi_operand_sum_using_fifos

Parametrised N-operand adder with per-operand input FIFOs and an output FIFO, all on valid/ready handshakes. It is the generalised successor of the two-operand double-buffered adder: operand count, buffer depths and overflow mode are configurable, and any operand may run ahead of the others up to its FIFO depth. It sits between independent producer streams and a single consumer in the datapath.

## Interface
- `width`, 8: bit width of every operand and of the sum.
- `n_inputs`, 3: number of operand channels; legal range 2..16.
- `in_depth`, 4: entries per input FIFO; power of two, ≥ 2.
- `out_depth`, 4: entries in the output FIFO; power of two, ≥ 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  n_inputs  per-channel valid; bit i belongs to channel i.
- `in_ready`  output  n_inputs  per-channel ready.
- `in_data`  input  n_inputs*width  channel i occupies bits [i*width +: width].
- `sum_valid`  output  1  output FIFO non-empty.
- `sum_ready`  input  1  consumer accepts sum.
- `sum_data`  output  width  sum at the output FIFO head.

## Operation
- Channel i handshake: `in_valid[i] & in_ready[i]` pushes `in_data` slice i into input FIFO i.
- Join fires in a cycle when every input FIFO is non-empty and the output FIFO is not full.
- On join: pop one entry from every input FIFO and push their sum into the output FIFO, same edge. No partial pops.
- Sum: all `n_inputs` heads added at `width + $clog2(n_inputs)` bits internally, then reduced to `width` (see Configuration).
- Output handshake: `sum_valid & sum_ready` pops the output FIFO head.
- Channels are independent: a stalled channel never blocks pushes into the others until they are full.
- Ordering: the k-th sum is built from the k-th accepted item of each channel.
- Pointer wrap: read/write pointers carry one extra bit for full/empty; full = equal index with differing wrap bit.

## Timing
- Reset (`rst` low, asynchronous): all FIFOs empty, pointers 0, `sum_valid` = 0, `sum_data` = 0, `in_ready` = all 0.
- `in_ready` is driven by a registered enable that is set on the first rising edge after `rst` is released. From then on, `in_ready[i]` = input FIFO i not full, registered-state only, with no combinational path from `sum_ready` or `in_valid`.
- A full input FIFO does not accept a push in the same cycle it is popped. `in_ready` rises the cycle after the pop.
- A full output FIFO does not accept a join in the same cycle `sum_ready` pops it. The join fires the next cycle.
- `sum_data` = 0 whenever `sum_valid` = 0, and is otherwise the head entry.
- Latency: the last operand accepted at edge N gives join at edge N+1 and `sum_valid` high after edge N+1. The minimum is 2 edges from input handshake to the sum being popped.
- Throughput: one sum per cycle sustained when all channels are valid and `sum_ready` is held high.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the count is unchanged.
- Reset mid-operation: all contents are discarded immediately and no sum is emitted afterwards.

## Configuration
- `MULTI_OPERAND_SUM_SATURATE_EN` defined: the sum saturates at `2**width - 1` if the wide sum exceeds it.
- Not defined: the sum wraps modulo `2**width`, keeping the low `width` bits.

## Test plan
- Reset release, all valids high, `sum_ready` high, defaults: channels send 1, 2, 3 → `in_ready` = 3'b000 during reset and 3'b111 one edge after release; `sum_data` = 6 two edges after acceptance; one sum per cycle thereafter.
- Skew: channel 0 pushes 10, 20, 30, 40 while channels 1 and 2 are idle → `in_ready[0]` drops after 4 pushes. Channels 1 and 2 each then push 1, 1, 1, 1 → sums 12, 22, 32, 42 in order.
- Backpressure: `sum_ready` low with 8 operand sets offered → output FIFO holds 4 sums, input FIFOs hold 4 each, and all `in_ready` are 0. Raising `sum_ready` drains all 8 in order with none lost or duplicated.
- Overflow: operands 200, 100, 50 → sum 94 without the macro; sum 255 with `MULTI_OPERAND_SUM_SATURATE_EN`.
- Async reset while output FIFO holds 3 sums → `sum_valid` and `sum_data` go to 0 without a clock edge; no stale sum appears after release.
- Random valid/ready at 50 %, `n_inputs` = 5, `in_depth` = 2, `out_depth` = 8, 1000 sets → scoreboard matches every sum and no handshake rule is violated.
